dma64_mem_responder: RTL and testbench
======================================

# dma64_mem_responder

Memory-side responder for the 64-bit accelerator DMA protocol: accepts read/write control requests from an accelerator, streams 64-bit beats out of an internal word memory on reads, and commits incoming beats on writes. Sits between a DMA-initiator accelerator and the testbench or host, acting as the accelerator's memory system. A host port preloads input frames and dumps results while the responder is idle.

## Interface
- MEM_WORDS, 1024: memory depth in 64-bit words; power of two.
- ADDR_W, $clog2(MEM_WORDS): word address width, derived.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- dma_read_ctrl_valid  in  1  read request valid.
- dma_read_ctrl_data_index  in  32  start word index.
- dma_read_ctrl_data_length  in  32  beat count.
- dma_read_ctrl_data_size  in  3  beat size code; 3 = 8 bytes.
- dma_read_ctrl_ready  out  1  read request accepted.
- dma_read_chnl_valid  out  1  read beat valid.
- dma_read_chnl_data  out  64  read beat.
- dma_read_chnl_ready  in  1  accelerator takes beat.
- dma_write_ctrl_valid / _data_index / _data_length / _data_size  in  1/32/32/3  write request, same meaning.
- dma_write_ctrl_ready  out  1  write request accepted.
- dma_write_chnl_valid  in  1  write beat valid.
- dma_write_chnl_data  in  64  write beat.
- dma_write_chnl_ready  out  1  responder takes beat.
- host_en  in  1  host access strobe; honored only in S_IDLE.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  64  host write data.
- host_rdata  out  64  mem[host_addr], combinational.
- busy  out  1  state != S_IDLE.
- xfer_done  out  1  one-cycle pulse after last beat of a burst.
- err_size  out  1  sticky: request with size != 3.
- err_range  out  1  sticky: burst crossed MEM_WORDS.
- err_host  out  1  sticky: host_en while busy.

## Operation
- States: S_IDLE, S_RD, S_WR.
- S_IDLE: if dma_read_ctrl_valid, assert dma_read_ctrl_ready (combinational), latch index/length, go S_RD; else if dma_write_ctrl_valid, assert dma_write_ctrl_ready, go S_WR. Read wins when both valid; the loser's ready stays 0 and it is served after the read burst.
- Ctrl ready is never asserted outside S_IDLE.
- Length 0: handshake accepted, state stays S_IDLE, xfer_done pulses next cycle, no beats.
- S_RD: dma_read_chnl_valid=1, data=mem[addr]. On valid&ready: addr+1, remaining-1; on last beat go S_IDLE, pulse xfer_done.
- S_WR: dma_write_chnl_ready=1. On valid&ready: mem[addr]<=data, addr+1, remaining-1; on last beat go S_IDLE, pulse xfer_done.
- Address: index[ADDR_W-1:0] + beat offset, modulo MEM_WORDS. If index >= MEM_WORDS or index+length > MEM_WORDS, set err_range; transfer still proceeds with wrap.
- Size != 3: set err_size; beats still treated as 64-bit.
- Remaining counter 32-bit; no width truncation of length.
- Host: host write commits at clock edge when host_en&host_we in S_IDLE; host_en while busy is dropped and sets err_host. Error flags clear only on reset.

## Timing
- Reset values: all readys/valids 0, dma_read_chnl_data 0 (gated by valid), busy 0, xfer_done 0, err_* 0, state S_IDLE. Memory contents not reset.
- Ctrl handshake at edge T -> first read beat valid in cycle T+1; one beat per cycle under continuous ready.
- Backpressure: while dma_read_chnl_ready=0, valid and data held stable.
- After last beat at edge T, S_IDLE at T+1; next ctrl handshake possible at edge T+1.
- Write beat data visible on host_rdata the cycle after its handshake.
- Reset mid-burst: immediate return to S_IDLE; partial writes already committed remain.

## Configuration
- DMA64_RESP_STALL_EN defined: 16-bit LFSR (seed 0xACE1, taps 16,14,13,11) gates dma_read_chnl_valid and dma_write_chnl_ready low on cycles where LFSR bit 0 is 1, to stress accelerator backpressure handling; ctrl ready unaffected.
- Undefined: no stall insertion; full-throughput timing above.

## Structure
- Package dma64_pkg: state enum, DMA_SIZE_64 = 3'd3 constant, beat width 64.
- Sub-module dma64_word_mem: MEM_WORDS x 64 array, one synchronous write port (muxed DMA/host), two combinational read ports (DMA addr, host_addr).

## Test plan
- Host-preload mem[2..5]=0x11..,0x22..,0x33..,0x44..; read index 2 length 4, ready held 1 -> four beats in order on cycles T+1..T+4, xfer_done at T+5.
- Write index 5 length 1 data 0x0123456789ABCDEF -> host_rdata at addr 5 equals it; busy 0 afterward.
- Read and write ctrl valid same cycle -> only dma_read_ctrl_ready=1; write accepted after read burst completes.
- Read length 0 -> no read beats, xfer_done pulse, state S_IDLE.
- Read index MEM_WORDS-1 length 2 -> beats mem[1023], mem[0]; err_range=1.
- Toggle dma_read_chnl_ready 1,0,0,1 -> data stable during stalls; size=2 request -> err_size=1.

Source files
------------

// File: rtl/dma64_pkg.sv
// Shared types and constants for the 64-bit DMA memory responder.
package dma64_pkg;

   localparam int BEAT_W = 64;
   localparam logic [2:0] DMA_SIZE_64 = 3'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_e;

   // True when a burst starting at index with length beats leaves the memory window.
   function automatic logic burst_out_of_range(input logic [31:0] index,
                                               input logic [31:0] length,
                                               input int unsigned mem_words);
      logic [32:0] limit_s;
      logic [32:0] end_s;
      limit_s = 33'(mem_words);
      end_s   = {1'b0, index} + {1'b0, length};
      return ({1'b0, index} >= limit_s) || (end_s > limit_s);
   endfunction

endpackage

// File: rtl/dma64_word_mem.sv
// Word memory for the DMA responder: one synchronous write port, two combinational read ports.
module dma64_word_mem
   import dma64_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [BEAT_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [BEAT_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [BEAT_W-1:0] rdata_b
);

   logic [BEAT_W-1:0] mem_q [MEM_WORDS];

   // Storage write; contents intentionally survive reset so host preloads are kept.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-side responder for the 64-bit accelerator DMA protocol with a host preload/dump port.
// Optional feature: define DMA64_RESP_STALL_EN to insert pseudo-random channel stalls.
module dma64_mem_responder
   import dma64_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dma_read_ctrl_valid,
   input  logic [31:0]       dma_read_ctrl_data_index,
   input  logic [31:0]       dma_read_ctrl_data_length,
   input  logic [2:0]        dma_read_ctrl_data_size,
   output logic              dma_read_ctrl_ready,
   output logic              dma_read_chnl_valid,
   output logic [63:0]       dma_read_chnl_data,
   input  logic              dma_read_chnl_ready,
   input  logic              dma_write_ctrl_valid,
   input  logic [31:0]       dma_write_ctrl_data_index,
   input  logic [31:0]       dma_write_ctrl_data_length,
   input  logic [2:0]        dma_write_ctrl_data_size,
   output logic              dma_write_ctrl_ready,
   input  logic              dma_write_chnl_valid,
   input  logic [63:0]       dma_write_chnl_data,
   output logic              dma_write_chnl_ready,
   input  logic              host_en,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [63:0]       host_wdata,
   output logic [63:0]       host_rdata,
   output logic              busy,
   output logic              xfer_done,
   output logic              err_size,
   output logic              err_range,
   output logic              err_host
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       rem_q, rem_d;
   logic              xfer_done_q, xfer_done_d;
   logic              err_size_q, err_size_d;
   logic              err_range_q, err_range_d;
   logic              err_host_q, err_host_d;

   logic              stall_s;
   logic              rd_beat_s;
   logic              wr_beat_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [63:0]       mem_wdata_s;
   logic [63:0]       dma_rdata_s;
   logic [ADDR_W-1:0] addr_inc_s;

`ifdef DMA64_RESP_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Next LFSR value, taps 16,14,13,11.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Free-running stall pattern generator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall_s = lfsr_q[0];
`else
   assign stall_s = 1'b0;
`endif

   assign addr_inc_s = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign rd_beat_s  = (state_q == S_RD) && !stall_s && dma_read_chnl_ready;
   assign wr_beat_s  = (state_q == S_WR) && !stall_s && dma_write_chnl_valid;

   // Request arbitration, beat accounting, sticky errors and memory write muxing.
   always_comb begin
      state_d              = state_q;
      addr_d               = addr_q;
      rem_d                = rem_q;
      xfer_done_d          = 1'b0;
      err_size_d           = err_size_q;
      err_range_d          = err_range_q;
      err_host_d           = err_host_q;
      dma_read_ctrl_ready  = 1'b0;
      dma_write_ctrl_ready = 1'b0;
      dma_read_chnl_valid  = 1'b0;
      dma_write_chnl_ready = 1'b0;
      mem_we_s             = 1'b0;
      mem_waddr_s          = addr_q;
      mem_wdata_s          = dma_write_chnl_data;

      case (state_q)
         S_IDLE: begin
            if (dma_read_ctrl_valid) begin
               dma_read_ctrl_ready = 1'b1;
               addr_d      = dma_read_ctrl_data_index[ADDR_W-1:0];
               rem_d       = dma_read_ctrl_data_length;
               err_size_d  = err_size_q | (dma_read_ctrl_data_size != DMA_SIZE_64);
               err_range_d = err_range_q | burst_out_of_range(dma_read_ctrl_data_index,
                                                              dma_read_ctrl_data_length,
                                                              MEM_WORDS);
               if (dma_read_ctrl_data_length == 32'd0) begin
                  xfer_done_d = 1'b1;
               end else begin
                  state_d = S_RD;
               end
            end else if (dma_write_ctrl_valid) begin
               dma_write_ctrl_ready = 1'b1;
               addr_d      = dma_write_ctrl_data_index[ADDR_W-1:0];
               rem_d       = dma_write_ctrl_data_length;
               err_size_d  = err_size_q | (dma_write_ctrl_data_size != DMA_SIZE_64);
               err_range_d = err_range_q | burst_out_of_range(dma_write_ctrl_data_index,
                                                              dma_write_ctrl_data_length,
                                                              MEM_WORDS);
               if (dma_write_ctrl_data_length == 32'd0) begin
                  xfer_done_d = 1'b1;
               end else begin
                  state_d = S_WR;
               end
            end else begin
               state_d = S_IDLE;
            end

            // The host owns the write port only while no burst is running.
            if (host_en && host_we) begin
               mem_we_s    = 1'b1;
               mem_waddr_s = host_addr;
               mem_wdata_s = host_wdata;
            end else begin
               mem_we_s = 1'b0;
            end
         end

         S_RD: begin
            dma_read_chnl_valid = !stall_s;
            err_host_d          = err_host_q | host_en;
            if (rd_beat_s) begin
               addr_d = addr_inc_s;
               rem_d  = rem_q - 32'd1;
               if (rem_q == 32'd1) begin
                  state_d     = S_IDLE;
                  xfer_done_d = 1'b1;
               end else begin
                  state_d = S_RD;
               end
            end else begin
               state_d = S_RD;
            end
         end

         S_WR: begin
            dma_write_chnl_ready = !stall_s;
            err_host_d           = err_host_q | host_en;
            if (wr_beat_s) begin
               mem_we_s = 1'b1;
               addr_d   = addr_inc_s;
               rem_d    = rem_q - 32'd1;
               if (rem_q == 32'd1) begin
                  state_d     = S_IDLE;
                  xfer_done_d = 1'b1;
               end else begin
                  state_d = S_WR;
               end
            end else begin
               state_d = S_WR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, burst counters and sticky status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         rem_q       <= 32'd0;
         xfer_done_q <= 1'b0;
         err_size_q  <= 1'b0;
         err_range_q <= 1'b0;
         err_host_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         xfer_done_q <= xfer_done_d;
         err_size_q  <= err_size_d;
         err_range_q <= err_range_d;
         err_host_q  <= err_host_d;
      end
   end

   dma64_word_mem #(
      .MEM_WORDS (MEM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we_s),
      .waddr   (mem_waddr_s),
      .wdata   (mem_wdata_s),
      .raddr_a (addr_q),
      .rdata_a (dma_rdata_s),
      .raddr_b (host_addr),
      .rdata_b (host_rdata)
   );

   assign dma_read_chnl_data = dma_read_chnl_valid ? dma_rdata_s : {BEAT_W{1'b0}};
   assign busy               = (state_q != S_IDLE);
   assign xfer_done          = xfer_done_q;
   assign err_size           = err_size_q;
   assign err_range          = err_range_q;
   assign err_host           = err_host_q;

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Self-checking bench for dma64_mem_responder: directed cases plus randomized bursts vs. a word-array model.
module tb_dma64_mem_responder;

   localparam int M  = 1024;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_read_ctrl_valid;
   logic [31:0] dma_read_ctrl_data_index;
   logic [31:0] dma_read_ctrl_data_length;
   logic [2:0]  dma_read_ctrl_data_size;
   logic        dma_read_ctrl_ready;
   logic        dma_read_chnl_valid;
   logic [63:0] dma_read_chnl_data;
   logic        dma_read_chnl_ready;
   logic        dma_write_ctrl_valid;
   logic [31:0] dma_write_ctrl_data_index;
   logic [31:0] dma_write_ctrl_data_length;
   logic [2:0]  dma_write_ctrl_data_size;
   logic        dma_write_ctrl_ready;
   logic        dma_write_chnl_valid;
   logic [63:0] dma_write_chnl_data;
   logic        dma_write_chnl_ready;
   logic        host_en;
   logic        host_we;
   logic [AW-1:0] host_addr;
   logic [63:0] host_wdata;
   logic [63:0] host_rdata;
   logic        busy;
   logic        xfer_done;
   logic        err_size;
   logic        err_range;
   logic        err_host;

   always #5 clk = ~clk;

   dma64_mem_responder #(.MEM_WORDS(M)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .dma_read_ctrl_valid        (dma_read_ctrl_valid),
      .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
      .dma_read_ctrl_ready        (dma_read_ctrl_ready),
      .dma_read_chnl_valid        (dma_read_chnl_valid),
      .dma_read_chnl_data         (dma_read_chnl_data),
      .dma_read_chnl_ready        (dma_read_chnl_ready),
      .dma_write_ctrl_valid       (dma_write_ctrl_valid),
      .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
      .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
      .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
      .dma_write_ctrl_ready       (dma_write_ctrl_ready),
      .dma_write_chnl_valid       (dma_write_chnl_valid),
      .dma_write_chnl_data        (dma_write_chnl_data),
      .dma_write_chnl_ready       (dma_write_chnl_ready),
      .host_en                    (host_en),
      .host_we                    (host_we),
      .host_addr                  (host_addr),
      .host_wdata                 (host_wdata),
      .host_rdata                 (host_rdata),
      .busy                       (busy),
      .xfer_done                  (xfer_done),
      .err_size                   (err_size),
      .err_range                  (err_range),
      .err_host                   (err_host)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] mdl [M];
   bit          m_err_size, m_err_range, m_err_host;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int wrap(input logic [31:0] idx, input int k);
      longint unsigned s;
      s = longint'(idx) + longint'(k);
      return int'(s % M);
   endfunction

   task automatic note_request(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
      longint unsigned i, l;
      i = idx;
      l = len;
      if (sz != 3'd3) m_err_size = 1'b1;
      if (i >= M || i + l > M) m_err_range = 1'b1;
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_err_size"}, err_size, m_err_size);
      chk({tag, "_err_range"}, err_range, m_err_range);
      chk({tag, "_err_host"}, err_host, m_err_host);
   endtask

   task automatic host_write(input int a, input logic [63:0] d);
      host_en = 1'b1; host_we = 1'b1; host_addr = a[AW-1:0]; host_wdata = d;
      tick();
      host_en = 1'b0; host_we = 1'b0;
      mdl[a] = d;
   endtask

   task automatic host_check(input string tag, input int a);
      host_addr = a[AW-1:0];
      #1;
      chk(tag, host_rdata, mdl[a]);
   endtask

   // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready
   task automatic dma_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                           input int mode, input bit poke, output int cycles);
      int k = 0;
      int cyc = 0;
      bit prev_stall = 1'b0;
      logic [63:0] prev_d = 64'd0;
      dma_read_ctrl_valid = 1'b1;
      dma_read_ctrl_data_index = idx;
      dma_read_ctrl_data_length = len;
      dma_read_ctrl_data_size = sz;
      dma_read_chnl_ready = 1'b0;
      #1;
      chk("rd_ctrl_ready", dma_read_ctrl_ready, 1'b1);
      chk("wr_ctrl_ready_lose", dma_write_ctrl_ready, 1'b0);
      tick();
      dma_read_ctrl_valid = 1'b0;
      note_request(idx, len, sz);
      if (len == 32'd0) begin
         chk("rd0_done", xfer_done, 1'b1);
         chk("rd0_busy", busy, 1'b0);
         chk("rd0_valid", dma_read_chnl_valid, 1'b0);
         cycles = 0;
         return;
      end
      while (k < int'(len) && cyc < 200) begin
         if (mode == 0) dma_read_chnl_ready = 1'b1;
         else if (mode == 1) dma_read_chnl_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         else dma_read_chnl_ready = 1'($urandom_range(0, 1));
         if (poke && cyc == 0) begin
            host_en = 1'b1; host_we = 1'b1; host_addr = 10'd700; host_wdata = ~mdl[700];
            m_err_host = 1'b1;
         end
         #1;
         chk("rd_valid", dma_read_chnl_valid, 1'b1);
         chk("rd_busy", busy, 1'b1);
         chk("rd_ctrl_ready_busy", dma_read_ctrl_ready | dma_write_ctrl_ready, 1'b0);
         chk("rd_data", dma_read_chnl_data, mdl[wrap(idx, k)]);
         if (prev_stall) chk("rd_stable", dma_read_chnl_data, prev_d);
         chk("rd_done_early", xfer_done, 1'b0);
         prev_stall = !dma_read_chnl_ready;
         prev_d = dma_read_chnl_data;
         if (dma_read_chnl_ready) k++;
         tick();
         cyc++;
         host_en = 1'b0; host_we = 1'b0;
      end
      dma_read_chnl_ready = 1'b0;
      if (k < int'(len)) chk("rd_timeout", 64'(k), 64'(len));
      chk("rd_done", xfer_done, 1'b1);
      chk("rd_idle", busy, 1'b0);
      chk("rd_valid_off", dma_read_chnl_valid, 1'b0);
      cycles = cyc;
   endtask

   task automatic dma_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                            input bit fixed, input logic [63:0] fdata);
      int k = 0;
      int cyc = 0;
      dma_write_ctrl_valid = 1'b1;
      dma_write_ctrl_data_index = idx;
      dma_write_ctrl_data_length = len;
      dma_write_ctrl_data_size = sz;
      #1;
      chk("wr_ctrl_ready", dma_write_ctrl_ready, 1'b1);
      tick();
      dma_write_ctrl_valid = 1'b0;
      note_request(idx, len, sz);
      if (len == 32'd0) begin
         chk("wr0_done", xfer_done, 1'b1);
         chk("wr0_busy", busy, 1'b0);
         return;
      end
      while (k < int'(len) && cyc < 200) begin
         dma_write_chnl_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
         dma_write_chnl_data = fixed ? fdata : {$urandom, $urandom};
         #1;
         chk("wr_chnl_ready", dma_write_chnl_ready, 1'b1);
         chk("wr_busy", busy, 1'b1);
         if (dma_write_chnl_valid) begin
            mdl[wrap(idx, k)] = dma_write_chnl_data;
            k++;
         end
         tick();
         cyc++;
      end
      dma_write_chnl_valid = 1'b0;
      if (k < int'(len)) chk("wr_timeout", 64'(k), 64'(len));
      chk("wr_done", xfer_done, 1'b1);
      chk("wr_idle", busy, 1'b0);
      for (int j = 0; j < int'(len); j++) host_check("wr_commit", wrap(idx, j));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic [31:0] ridx, rlen;
      logic [2:0]  rsz;

      rst = 1'b0;
      dma_read_ctrl_valid = 1'b0; dma_read_ctrl_data_index = 32'd0;
      dma_read_ctrl_data_length = 32'd0; dma_read_ctrl_data_size = 3'd3;
      dma_read_chnl_ready = 1'b0;
      dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = 32'd0;
      dma_write_ctrl_data_length = 32'd0; dma_write_ctrl_data_size = 3'd3;
      dma_write_chnl_valid = 1'b0; dma_write_chnl_data = 64'd0;
      host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 64'd0;
      m_err_size = 1'b0; m_err_range = 1'b0; m_err_host = 1'b0;

      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_valid", dma_read_chnl_valid, 1'b0);
      chk("rst_rd_data", dma_read_chnl_data, 64'd0);
      chk("rst_wr_ready", dma_write_chnl_ready, 1'b0);
      chk("rst_ctrl_ready", dma_read_ctrl_ready | dma_write_ctrl_ready, 1'b0);
      chk("rst_xfer_done", xfer_done, 1'b0);
      check_flags("rst");
      rst = 1'b1;
      tick();

      for (int a = 0; a < M; a++) host_write(a, {$urandom, $urandom});
      host_write(2, 64'h1111111111111111);
      host_write(3, 64'h2222222222222222);
      host_write(4, 64'h3333333333333333);
      host_write(5, 64'h4444444444444444);
      host_check("preload", 3);

      dma_read(32'd2, 32'd4, 3'd3, 0, 1'b0, cyc);
      chk("rd4_cycles", 64'(cyc), 64'd4);
      tick();
      chk("done_pulse_width", xfer_done, 1'b0);

      dma_write(32'd5, 32'd1, 3'd3, 1'b1, 64'h0123456789ABCDEF);
      host_addr = 10'd5;
      #1;
      chk("wr5_value", host_rdata, 64'h0123456789ABCDEF);
      chk("wr5_busy", busy, 1'b0);

      dma_write_ctrl_valid = 1'b1;
      dma_write_ctrl_data_index = 32'd20;
      dma_write_ctrl_data_length = 32'd2;
      dma_write_ctrl_data_size = 3'd3;
      dma_read(32'd10, 32'd3, 3'd3, 2, 1'b0, cyc);
      dma_write(32'd20, 32'd2, 3'd3, 1'b0, 64'd0);

      dma_read(32'd50, 32'd0, 3'd3, 0, 1'b0, cyc);
      check_flags("len0");

      dma_read(32'(M - 1), 32'd2, 3'd3, 0, 1'b0, cyc);
      check_flags("wrap");

      dma_read(32'd100, 32'd5, 3'd2, 1, 1'b0, cyc);
      check_flags("size2");

      dma_read(32'd300, 32'd3, 3'd3, 0, 1'b1, cyc);
      host_check("host_drop", 700);
      check_flags("host_busy");

      dma_write_ctrl_valid = 1'b1;
      dma_write_ctrl_data_index = 32'd40;
      dma_write_ctrl_data_length = 32'd4;
      dma_write_ctrl_data_size = 3'd3;
      tick();
      dma_write_ctrl_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
         dma_write_chnl_valid = 1'b1;
         dma_write_chnl_data = {$urandom, $urandom};
         mdl[40 + j] = dma_write_chnl_data;
         tick();
      end
      dma_write_chnl_valid = 1'b0;
      rst = 1'b0;
      m_err_size = 1'b0; m_err_range = 1'b0; m_err_host = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_wr_ready", dma_write_chnl_ready, 1'b0);
      check_flags("midrst");
      tick();
      rst = 1'b1;
      tick();
      host_check("midrst_keep0", 40);
      host_check("midrst_keep1", 41);

      for (int it = 0; it < 30; it++) begin
         ridx = 32'($urandom_range(0, M - 1));
         if ($urandom_range(0, 7) == 0) ridx = 32'(M - $urandom_range(1, 3));
         if ($urandom_range(0, 11) == 0) ridx = 32'(M + $urandom_range(0, 50));
         rlen = 32'($urandom_range(0, 6));
         rsz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
         if ($urandom_range(0, 1) == 1) dma_read(ridx, rlen, rsz, 2, 1'b0, cyc);
         else dma_write(ridx, rlen, rsz, 1'b0, 64'd0);
         check_flags("rnd");
      end

      for (int j = 0; j < 32; j++) host_check("dump", $urandom_range(0, M - 1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
